// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator for raster-order pixels (valid-mode, no padding).
// Two line buffers feed the right column of the window; output is packed for mult_add's input.
module conv_window_gen #(
  parameter int I_BIT_WIDTH = 8,
  parameter int K_SIZE      = 3,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_pix_valid,
  input  logic [I_BIT_WIDTH-1:0]                i_pix_in,
  output logic                                  o_win_valid,
  output logic [I_BIT_WIDTH*K_SIZE*K_SIZE-1:0]  o_win_out,
  output logic                                  o_frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(K_SIZE - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(K_SIZE - 1);

  generate
    if (K_SIZE != 3) begin : g_bad_ksize
      $error("conv_window_gen: only K_SIZE=3 is supported");
    end
    if (IMG_W < K_SIZE || IMG_H < K_SIZE) begin : g_bad_img
      $error("conv_window_gen: image must be at least K_SIZE x K_SIZE");
    end
  endgenerate

  logic [CW-1:0]          r_col;
  logic [RW-1:0]          r_row;
  logic [I_BIT_WIDTH-1:0] r_lb1 [IMG_W];
  logic [I_BIT_WIDTH-1:0] r_lb2 [IMG_W];
  logic [I_BIT_WIDTH-1:0] r_win [K_SIZE][K_SIZE];
  logic [I_BIT_WIDTH-1:0] w_lb1_rd;
  logic [I_BIT_WIDTH-1:0] w_lb2_rd;

  assign w_lb1_rd = r_lb1[r_col];
  assign w_lb2_rd = r_lb2[r_col];

  // Line buffers carry no reset: stale contents are masked by the row/col valid qualification.
  always_ff @(posedge i_clk) begin
    if (i_pix_valid) begin
      r_lb1[r_col] <= i_pix_in;
      r_lb2[r_col] <= w_lb1_rd;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col        <= '0;
      r_row        <= '0;
      o_win_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      for (int i = 0; i < K_SIZE; i++)
        for (int j = 0; j < K_SIZE; j++)
          r_win[i][j] <= '0;
    end else begin
      o_win_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_pix_valid) begin
        for (int i = 0; i < K_SIZE; i++)
          for (int j = 0; j < K_SIZE - 1; j++)
            r_win[i][j] <= r_win[i][j+1];
        r_win[0][K_SIZE-1] <= w_lb2_rd;
        r_win[1][K_SIZE-1] <= w_lb1_rd;
        r_win[2][K_SIZE-1] <= i_pix_in;
        o_win_valid  <= (r_row >= ROW_MIN) && (r_col >= COL_MIN);
        o_frame_done <= (r_row == ROW_LAST) && (r_col == COL_LAST);
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_win_out = '0;
    for (int i = 0; i < K_SIZE; i++)
      for (int j = 0; j < K_SIZE; j++)
        o_win_out[I_BIT_WIDTH*(K_SIZE*i+j) +: I_BIT_WIDTH] = r_win[i][j];
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x4 image with pixel value base+4*r+c.
module tb_conv_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [7:0]  pix_in;
  logic        win_valid;
  logic [71:0] win_out;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;
  int nwin;
  logic [71:0] first_win, last_win;
  int exp_sum [4] = '{45, 54, 81, 90};

  conv_window_gen #(.I_BIT_WIDTH(8), .K_SIZE(3), .IMG_W(W), .IMG_H(H)) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pix_valid  (pix_valid),
    .i_pix_in     (pix_in),
    .o_win_valid  (win_valid),
    .o_win_out    (win_out),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] win_model(input logic [7:0] base, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = base + 8'(4*(r-2+i) + (c-2+j));
    return w;
  endfunction

  function automatic int sum9(input logic [71:0] w);
    int s;
    s = 0;
    for (int e = 0; e < 9; e++) s += int'(w[8*e +: 8]);
    return s;
  endfunction

  task automatic push(input logic [7:0] base, input int r, input int c,
                      input int gap, input bit do_sum);
    bit          exp_v;
    logic [71:0] exp_w;
    @(negedge clk);
    pix_valid = 1'b1;
    pix_in    = base + 8'(4*r + c);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    exp_v = (r >= 2) && (c >= 2);
    exp_w = win_model(base, r, c);
    chk("win_valid", 72'(win_valid), 72'(exp_v));
    chk("frame_done", 72'(frame_done), 72'((r == H-1) && (c == W-1)));
    if (exp_v) begin
      chk("win_out", win_out, exp_w);
      if (do_sum) chk("mac_sum", 72'(sum9(win_out)), 72'(exp_sum[nwin]));
      if (nwin == 0) first_win = win_out;
      last_win = win_out;
      nwin++;
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      chk("gap_valid", 72'(win_valid), 72'(0));
      chk("gap_done", 72'(frame_done), 72'(0));
      if (exp_v) chk("gap_hold", win_out, exp_w);
    end
  endtask

  task automatic run_frame(input logic [7:0] base, input bit gaps, input bit do_sum);
    nwin = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        push(base, r, c, gaps ? int'($urandom_range(1, 3)) : 0, do_sum);
    chk("win_count", 72'(nwin), 72'(4));
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 72'(win_valid), 72'(0));
    chk("rst_done", 72'(frame_done), 72'(0));
    chk("rst_win", win_out, 72'(0));
    @(negedge clk) rst = 1'b0;

    // Test 1: continuous stream, MAC sums with unit weights
    run_frame(8'd0, 1'b0, 1'b1);
    chk("t1_first", first_win, 72'h0A0908060504020100);
    chk("t1_last", last_win, 72'h0F0E0D0B0A09070605);

    // Test 2: random idle gaps between pixels
    run_frame(8'd0, 1'b1, 1'b0);
    chk("t2_first", first_win, 72'h0A0908060504020100);
    chk("t2_last", last_win, 72'h0F0E0D0B0A09070605);

    // Test 3: two frames back-to-back
    run_frame(8'd0, 1'b0, 1'b0);
    run_frame(8'd100, 1'b0, 1'b0);
    chk("t3_first", first_win, 72'h6E6D6C6A6968666564);

    // Test 4: async reset mid-frame after pixel 9
    for (int p = 0; p < 10; p++) push(8'd0, p / W, p % W, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_win", win_out, 72'(0));
    chk("t4_rst_valid", 72'(win_valid), 72'(0));
    chk("t4_rst_done", 72'(frame_done), 72'(0));
    @(negedge clk) rst = 1'b0;
    run_frame(8'd0, 1'b0, 1'b1);
    chk("t4_first", first_win, 72'h0A0908060504020100);
    chk("t4_last", last_win, 72'h0F0E0D0B0A09070605);

    // Test 5: sign-bit pixels pass through untouched
    run_frame(8'h80, 1'b0, 1'b0);
    chk("t5_e0", 72'(first_win[7:0]), 72'h80);
    chk("t5_e8", 72'(first_win[71:64]), 72'h8A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
